// File: rtl/hps_avalon_slave_if.sv
// rtl/hps_avalon_slave_if.sv - HPS Avalon bridge and CPU-memory bus signals
interface hps_avalon_slave_if;
  logic [23:0] avalon_address;
  logic [3:0]  avalon_byte_enable;
  logic        avalon_read;
  logic        avalon_write;
  logic [31:0] avalon_write_data;
  logic        avalon_acknowledge;
  logic [31:0] avalon_read_data;
  logic        mem_req;
  logic        mem_we;
  logic [21:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  avalon_address, avalon_byte_enable, avalon_read, avalon_write,
           avalon_write_data, mem_ready, mem_rdata,
    output avalon_acknowledge, avalon_read_data, mem_req, mem_we, mem_addr,
           mem_be, mem_wdata
  );

  modport master (
    output avalon_address, avalon_byte_enable, avalon_read, avalon_write,
           avalon_write_data, mem_ready, mem_rdata,
    input  avalon_acknowledge, avalon_read_data, mem_req, mem_we, mem_addr,
           mem_be, mem_wdata
  );
endinterface

// File: rtl/hps_avalon_slave.sv
// rtl/hps_avalon_slave.sv - HPS Avalon slave bridging to CPU memory and control registers
// Optional mem_ready timeout enabled by defining HPS_SLAVE_TIMEOUT_EN.
module hps_avalon_slave #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                resetn,
  hps_avalon_slave_if.slave   bus,
  output logic                cpu_hold,
  output logic                cpu_reset_req,
  output logic                error
);
  typedef enum logic [2:0] {IDLE, MEM, REG, ACK, DRAIN} state_t;

  state_t      state, state_next;
  logic [21:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [31:0] rdata_q;
  logic [31:0] scratch;
  logic [31:0] reg_rdata;
  logic        req;
  logic        timeout;
  logic        status_clear;

  assign req = bus.avalon_read | bus.avalon_write;

`ifdef HPS_SLAVE_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // Counter holds zero outside MEM, so every entry into MEM starts from zero.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      tmo_cnt <= 8'd0;
    else if (state != MEM)
      tmo_cnt <= 8'd0;
    else
      tmo_cnt <= tmo_cnt + 8'd1;
  end

  assign timeout = (state == MEM) && !bus.mem_ready && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = bus.avalon_address[23] ? REG : MEM;
      MEM:     if (bus.mem_ready || timeout) state_next = ACK;
      REG:     state_next = ACK;
      ACK:     state_next = DRAIN;
      DRAIN:   if (!req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    reg_rdata = 32'd0;
    case (addr_q[1:0])
      2'd0:    reg_rdata = {30'd0, cpu_reset_req, cpu_hold};
      2'd1:    reg_rdata = {31'd0, error};
      2'd2:    reg_rdata = scratch;
      default: reg_rdata = 32'd0;
    endcase
  end

  assign status_clear = (state == REG) && we_q && (addr_q[1:0] == 2'd1) && be_q[0] && wdata_q[0];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      addr_q        <= 22'd0;
      be_q          <= 4'd0;
      wdata_q       <= 32'd0;
      we_q          <= 1'b0;
      rdata_q       <= 32'd0;
      scratch       <= 32'd0;
      cpu_hold      <= 1'b0;
      cpu_reset_req <= 1'b1;
      error         <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && req) begin
        addr_q  <= bus.avalon_address[21:0];
        be_q    <= bus.avalon_byte_enable;
        wdata_q <= bus.avalon_write_data;
        we_q    <= bus.avalon_write;
      end
      if (state == MEM && bus.mem_ready)
        rdata_q <= bus.mem_rdata;
      else if (timeout)
        rdata_q <= 32'hDEADBEEF;
      if (state == REG) begin
        rdata_q <= reg_rdata;
        if (we_q && addr_q[1:0] == 2'd0 && be_q[0]) begin
          cpu_hold      <= wdata_q[0];
          cpu_reset_req <= wdata_q[1];
        end
        if (we_q && addr_q[1:0] == 2'd2) begin
          for (int i = 0; i < 4; i++)
            if (be_q[i]) scratch[8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
      // A fresh error takes priority over a simultaneous W1C.
      if (timeout)
        error <= 1'b1;
      else if (status_clear)
        error <= 1'b0;
    end
  end

  assign bus.avalon_acknowledge = (state == ACK);
  assign bus.avalon_read_data   = (state == ACK && !we_q) ? rdata_q : 32'd0;
  assign bus.mem_req            = (state == MEM) && !timeout;
  assign bus.mem_we             = we_q;
  assign bus.mem_addr           = addr_q;
  assign bus.mem_be             = be_q;
  assign bus.mem_wdata          = wdata_q;
endmodule
